capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Next-generation capture/readback sequencer of the logic analyser core.
//  - Continuously writes strobed samples into a circular sample RAM.
//  - On trigger, captures 4*dly_cnt post-trigger samples.
//  - Then reads back 4*rd_cnt samples, newest first, to the UART transmitter through a ready/strobe handshake.
//  - Sits between the trigger unit / sampler and the sample RAM / transmitter. Width and depth are parametrised.
// PARAMETERS
//  WIDTH      32  sample and transmit word width
//  DEPTH      5   RAM address width; ring holds 2**DEPTH samples
//  CNT_WIDTH  16  width of rd_cnt_i / dly_cnt_i (in units of 4 samples)
// PORTS
//  clk_i      in   1          system clock; single clock domain
//  rst_in     in   1          reset, synchronous, active-low
//  set_cnt_i  in   1          load rd_cnt_i/dly_cnt_i into config regs
//  rd_cnt_i   in   CNT_WIDTH  readback count / 4
//  dly_cnt_i  in   CNT_WIDTH  post-trigger delay count / 4
//  run_i      in   1          trigger pulse
//  abort_i    in   1          cancel capture/readback
//  stb_i      in   1          sample valid
//  smpls_i    in   WIDTH      sample data
//  mem_d_i    in   WIDTH      RAM read data, valid 1 cycle after addr_o
//  tx_rdy_i   in   1          transmitter idle
//  we_o       out  1          RAM write enable
//  addr_o     out  DEPTH      RAM address (read and write)
//  mem_q_o    out  WIDTH      RAM write data = smpls_i (combinational)
//  tx_stb_o   out  1          1-cycle transmit strobe
//  tx_o       out  WIDTH      registered word for transmitter
//  busy_o     out  1          high in any state but IDLE
// BEHAVIOUR
//  - Reset (rst_in=0 at clk edge) returns all outputs to their reset values:
//    - state IDLE; ptr=0; cnt=0; tx_o=0; we_o=0; tx_stb_o=0; busy_o=0.
//    - Config regs reset to rd=1, dly=1.
//    - Reset mid-operation aborts immediately; no pending strobe is emitted.
//  - Config: set_cnt_i loads config regs only in IDLE; in other states it is ignored (dropped).
//  - Targets: dly_tgt = dly<<2 and rd_tgt = rd<<2, held in CNT_WIDTH+2-bit registers.
//  - Readback clamp: rd_tgt is clamped to 2**DEPTH.
//  - Pointer: ptr wraps mod 2**DEPTH. addr_o = ptr in IDLE/TRG, rd_ptr otherwise. we_o = stb_i in IDLE/TRG only.
//  - IDLE: each stb_i writes at ptr, then ptr++.
//    - run_i=1 -> TRG with cnt=0. A same-cycle stb_i is still written.
//  - TRG: while cnt<dly_tgt, each stb_i writes and increments ptr and cnt.
//    - When cnt==dly_tgt -> RD, with rd_ptr=ptr-1 (newest sample) and cnt=0.
//    - stb_i in the exit cycle is NOT written.
//    - dly=0 -> leaves TRG one cycle after entry.
//  - RD: if cnt==rd_tgt -> IDLE; otherwise addr_o=rd_ptr -> LOAD.
//  - LOAD: tx_o<=mem_d_i -> TX. RAM read latency is 1 cycle.
//  - TX: wait for tx_rdy_i=1.
//    - Then tx_stb_o=1 for exactly one cycle, cnt++, rd_ptr-- (wrapping) -> TX_WAIT.
//  - TX_WAIT: waits 1 cycle for tx_rdy_i to drop, then returns to RD.
//    - Max one strobe per transmitted word.
//  - Throughput: tx_stb_o is never asserted while tx_rdy_i=0.
//    - rd=0 -> RD returns to IDLE with no strobe.
//  - abort_i: any state -> IDLE next cycle.
//    - Suppresses tx_stb_o and we_o in the abort cycle.
//    - ptr is kept; cnt is cleared.
//  - Unused state encodings -> IDLE.
// CONFIGURATION
//  LOGIP_FILL_LIMIT_EN
//  - Defined:
//    - A fill counter (DEPTH+1 bits, saturating at 2**DEPTH) counts RAM writes since reset or abort.
//    - It is cleared on reset and on abort_i only.
//    - rd_tgt is further clamped to the fill count, so unwritten locations are never transmitted.
//  - Undefined: no fill counter; rd_tgt is clamped only to 2**DEPTH. Locations never written read back as RAM contents.
// TESTING
//  - Reset: assert rst_in=0 for 2 cycles mid-TX.
//    -> next cycle busy_o=0, tx_stb_o=0, addr_o=0; rd=dly=1 restored.
//  - DEPTH=5, rd=1, dly=1: 10 stb_i in IDLE, run_i, 4 more stb_i.
//    -> exactly 4 tx_stb_o carrying samples 14,13,12,11 (newest first).
//    -> busy_o=0 afterwards.
//  - Wrap: 40 strobes then trigger with dly=0, rd=8 (32 words).
//    -> words 40..9 transmitted; addr_o wraps from 0 to 31.
//  - Handshake: hold tx_rdy_i=0 for 20 cycles in TX.
//    -> no tx_stb_o; a single strobe follows within 1 cycle of tx_rdy_i=1.
//  - abort_i in TRG and in TX_WAIT -> IDLE next cycle; no further tx_stb_o.
//    - set_cnt_i in TRG -> config regs unchanged.
//  - LOGIP_FILL_LIMIT_EN: 3 writes after reset, run_i, dly=0, rd=2.
//    -> exactly 3 strobes (samples 2,1,0).
//    - Without the macro -> 8 strobes.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl -- capture/readback sequencer of the logic analyser core.
//
// Purpose
//   Writes strobed samples into a circular sample RAM. On a trigger it
//   captures 4*dly post-trigger samples. It then reads back up to 4*rd
//   samples, newest first, and hands them to the UART transmitter.
//
// Ports
//   clk_i, rst_in        clock; synchronous active-low reset
//   set_cnt_i            load rd_cnt_i / dly_cnt_i (accepted in IDLE only)
//   rd_cnt_i, dly_cnt_i  readback count / 4, post-trigger delay / 4
//   run_i, abort_i       trigger pulse, cancel capture/readback
//   stb_i, smpls_i       sample valid and sample data
//   mem_d_i              RAM read data, valid 1 cycle after addr_o
//   tx_rdy_i             transmitter idle
//   we_o, addr_o         RAM write enable and shared read/write address
//   mem_q_o              RAM write data (smpls_i passed through)
//   tx_stb_o, tx_o       1-cycle transmit strobe and registered word
//   busy_o               high in any state but IDLE
//   state_o              current FSM state, for debug and checkers
//
// Handshake: a word is transferred in the cycle where tx_stb_o is high;
// tx_stb_o is only raised while tx_rdy_i is high, and at most once per word.
//
// Build option
//   LOGIP_FILL_LIMIT_EN  when defined, a saturating fill counter limits
//                        readback to locations written since reset/abort.

module capture_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 set_cnt_i,
  input  logic [CNT_WIDTH-1:0] rd_cnt_i,
  input  logic [CNT_WIDTH-1:0] dly_cnt_i,
  input  logic                 run_i,
  input  logic                 abort_i,
  input  logic                 stb_i,
  input  logic [WIDTH-1:0]     smpls_i,
  input  logic [WIDTH-1:0]     mem_d_i,
  input  logic                 tx_rdy_i,
  output logic                 we_o,
  output logic [DEPTH-1:0]     addr_o,
  output logic [WIDTH-1:0]     mem_q_o,
  output logic                 tx_stb_o,
  output logic [WIDTH-1:0]     tx_o,
  output logic                 busy_o,
  output logic [2:0]           state_o
);

  localparam int TW = CNT_WIDTH + 2;
  // Ring size expressed in target width and in fill-counter width.
  localparam logic [TW-1:0]  RING     = TW'({1'b1, {DEPTH{1'b0}}});
  localparam logic [DEPTH:0] FILL_MAX = {1'b1, {DEPTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRG     = 3'd1,
    RD      = 3'd2,
    LOAD    = 3'd3,
    TX      = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [TW-1:0]    cnt;
  logic [TW-1:0]    rd_tgt;
  logic [TW-1:0]    dly_tgt;
  logic [TW-1:0]    rd_lim;
  logic             write_en;
  logic             tx_fire;

`ifdef LOGIP_FILL_LIMIT_EN
  logic [DEPTH:0] fill;

  always_ff @(posedge clk_i) begin
    if (!rst_in || abort_i) begin
      fill <= '0;
    end else if (write_en && fill != FILL_MAX) begin
      fill <= fill + 1'b1;
    end
  end
`endif

  // Effective readback length: never more than the ring holds (and, with
  // the fill limit, never more than has actually been written).
  always_comb begin
    rd_lim = (rd_tgt > RING) ? RING : rd_tgt;
`ifdef LOGIP_FILL_LIMIT_EN
    if (TW'(fill) < rd_lim) rd_lim = TW'(fill);
`endif
  end

  // Writes stop in the cycle TRG reaches its target; reset and abort
  // suppress both RAM writes and the transmit strobe immediately.
  assign write_en = rst_in && !abort_i && stb_i &&
                    (state == IDLE || (state == TRG && cnt != dly_tgt));
  assign tx_fire  = rst_in && !abort_i && (state == TX) && tx_rdy_i;

  assign we_o     = write_en;
  assign tx_stb_o = tx_fire;
  assign mem_q_o  = smpls_i;
  assign addr_o   = (state == IDLE || state == TRG) ? ptr : rd_ptr;
  assign busy_o   = (state != IDLE);
  assign state_o  = state;

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state   <= IDLE;
      ptr     <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      tx_o    <= '0;
      rd_tgt  <= TW'(4);
      dly_tgt <= TW'(4);
    end else if (abort_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (set_cnt_i) begin
            rd_tgt  <= {rd_cnt_i, 2'b00};
            dly_tgt <= {dly_cnt_i, 2'b00};
          end
          if (write_en) ptr <= ptr + 1'b1;
          if (run_i) begin
            state <= TRG;
            cnt   <= '0;
          end
        end
        TRG: begin
          if (cnt == dly_tgt) begin
            state  <= RD;
            rd_ptr <= ptr - 1'b1;  // newest sample
            cnt    <= '0;
          end else if (write_en) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        RD: begin
          if (cnt == rd_lim) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          // addr_o has held rd_ptr since RD, so mem_d_i is valid now.
          tx_o  <= mem_d_i;
          state <= TX;
        end
        TX: begin
          if (tx_fire) begin
            cnt    <= cnt + 1'b1;
            rd_ptr <= rd_ptr - 1'b1;
            state  <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // One idle cycle gives the transmitter time to drop tx_rdy_i.
          state <= RD;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl -- directed bench for capture_ctrl with a behavioural
// sample RAM (1-cycle read latency) and a strobe monitor.

module tb_capture_ctrl;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 5;
  localparam int CNT_WIDTH = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRG     = 3'd1;
  localparam logic [2:0] S_TX      = 3'd4;
  localparam logic [2:0] S_TX_WAIT = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                 rst_in;
  logic                 set_cnt_i;
  logic [CNT_WIDTH-1:0] rd_cnt_i;
  logic [CNT_WIDTH-1:0] dly_cnt_i;
  logic                 run_i;
  logic                 abort_i;
  logic                 stb_i;
  logic [WIDTH-1:0]     smpls_i;
  logic [WIDTH-1:0]     mem_d_i;
  logic                 tx_rdy_i;
  logic                 we_o;
  logic [DEPTH-1:0]     addr_o;
  logic [WIDTH-1:0]     mem_q_o;
  logic                 tx_stb_o;
  logic [WIDTH-1:0]     tx_o;
  logic                 busy_o;
  logic [2:0]           state_o;

  capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .set_cnt_i(set_cnt_i),
    .rd_cnt_i(rd_cnt_i), .dly_cnt_i(dly_cnt_i), .run_i(run_i),
    .abort_i(abort_i), .stb_i(stb_i), .smpls_i(smpls_i),
    .mem_d_i(mem_d_i), .tx_rdy_i(tx_rdy_i), .we_o(we_o), .addr_o(addr_o),
    .mem_q_o(mem_q_o), .tx_stb_o(tx_stb_o), .tx_o(tx_o), .busy_o(busy_o),
    .state_o(state_o)
  );

  // ---------------- sample RAM model ----------------
  logic [WIDTH-1:0] ram [2**DEPTH];
  always @(posedge clk_i) begin
    if (we_o) ram[addr_o] <= mem_q_o;
    mem_d_i <= ram[addr_o];
  end

  // ---------------- strobe monitor ----------------
  logic [WIDTH-1:0] got_q[$];
  always @(negedge clk_i) begin
    if (tx_stb_o) got_q.push_back(tx_o);
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare the words strobed since index 'base' against exp_q.
  task automatic check_words(input string tag, input int base);
    check({tag, "_count"}, WIDTH'(got_q.size() - base), WIDTH'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        check($sformatf("%s_w%0d", tag, i), got_q[base + i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic set_cfg(input int rd, input int dly);
    set_cnt_i = 1'b1;
    rd_cnt_i  = CNT_WIDTH'(rd);
    dly_cnt_i = CNT_WIDTH'(dly);
    tick();
    set_cnt_i = 1'b0;
  endtask

  task automatic send(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      stb_i   = 1'b1;
      smpls_i = WIDTH'(first + i);
      tick();
    end
    stb_i = 1'b0;
  endtask

  task automatic trigger();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, WIDTH'(busy_o), '0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state_o != s && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, WIDTH'(state_o), WIDTH'(s));
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    rst_in = 1'b0; set_cnt_i = 1'b0; rd_cnt_i = '0; dly_cnt_i = '0;
    run_i = 1'b0; abort_i = 1'b0; stb_i = 1'b0; smpls_i = '0;
    tx_rdy_i = 1'b1;
    tick(); tick(); tick();
    rst_in = 1'b1;
    check("rst_busy", WIDTH'(busy_o), '0);
    check("rst_addr", WIDTH'(addr_o), '0);
    check("rst_stb",  WIDTH'(tx_stb_o), '0);

    // Reset while waiting in TX: no strobe, everything back to IDLE.
    base = got_q.size();
    tx_rdy_i = 1'b0;
    trigger();
    send(100, 4);
    wait_state("prerst", S_TX, 40);
    rst_in = 1'b0;
    tx_rdy_i = 1'b1;
    #3;
    check("stb_during_rst", WIDTH'(tx_stb_o), '0);
    tick(); tick();
    rst_in = 1'b1;
    check("midrst_busy", WIDTH'(busy_o), '0);
    check("midrst_stb",  WIDTH'(tx_stb_o), '0);
    check("midrst_addr", WIDTH'(addr_o), '0);
    check("midrst_nostb", WIDTH'(got_q.size() - base), '0);

    // Default config rd=1, dly=1 after reset: 4 words, newest first.
    base = got_q.size();
    send(1, 10);
    trigger();
    send(11, 4);
    wait_idle("basic", 200);
    for (int v = 14; v >= 11; v--) exp_q.push_back(WIDTH'(v));
    check_words("basic", base);

    // Wrap: 40 samples, dly=0, rd=8 -> whole ring, samples 40 down to 9.
    do_reset();
    set_cfg(8, 0);
    base = got_q.size();
    send(1, 40);
    trigger();
    wait_idle("wrap", 400);
    for (int v = 40; v >= 9; v--) exp_q.push_back(WIDTH'(v));
    check_words("wrap", base);

    // Handshake: tx_rdy_i low for 20 cycles in TX.
    set_cfg(1, 0);
    tx_rdy_i = 1'b0;
    trigger();
    wait_state("hs", S_TX, 20);
    base = got_q.size();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("hs_hold%0d", i), WIDTH'(tx_stb_o), '0);
      tick();
    end
    check("hs_still_tx", WIDTH'(state_o), WIDTH'(S_TX));
    tx_rdy_i = 1'b1;
    #3;
    check("hs_stb_on_rdy", WIDTH'(tx_stb_o), 1);
    tick();
    check("hs_single", WIDTH'(got_q.size() - base), 1);
    wait_idle("hs", 200);
    // ptr=8 after 40 writes, so addresses 7..4 hold samples 40..37.
    for (int v = 40; v >= 37; v--) exp_q.push_back(WIDTH'(v));
    check_words("hs", base);

    // set_cnt_i in TRG is dropped: dly stays 1, rd stays 1.
    set_cfg(1, 1);
    trigger();
    set_cnt_i = 1'b1; rd_cnt_i = 16'd2; dly_cnt_i = 16'd0;
    tick();
    set_cnt_i = 1'b0;
    check("cfg_trg_hold", WIDTH'(state_o), WIDTH'(S_TRG));
    base = got_q.size();
    send(201, 4);
    wait_idle("cfg", 200);
    for (int v = 204; v >= 201; v--) exp_q.push_back(WIDTH'(v));
    check_words("cfg", base);

    // Abort in TRG: write suppressed in the abort cycle, IDLE next cycle.
    base = got_q.size();
    trigger();
    abort_i = 1'b1;
    stb_i = 1'b1;
    smpls_i = 32'd999;
    #1;
    check("abort_trg_we", WIDTH'(we_o), '0);
    tick();
    abort_i = 1'b0;
    stb_i = 1'b0;
    check("abort_trg_idle", WIDTH'(state_o), WIDTH'(S_IDLE));
    repeat (10) tick();
    check("abort_trg_nostb", WIDTH'(got_q.size() - base), '0);

    // Abort in TX_WAIT: the one strobe already sent, nothing after.
    base = got_q.size();
    trigger();
    send(301, 4);
    wait_state("abort_tw", S_TX_WAIT, 40);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_tw_idle", WIDTH'(busy_o), '0);
    repeat (20) tick();
    exp_q.push_back(WIDTH'(304));
    check_words("abort_tw", base);

    // Fill limit: 3 writes after reset, dly=0, rd=2.
    do_reset();
    set_cfg(2, 0);
    send(0, 3);
    base = got_q.size();
    trigger();
    wait_idle("fill", 200);
`ifdef LOGIP_FILL_LIMIT_EN
    for (int v = 2; v >= 0; v--) exp_q.push_back(WIDTH'(v));
    check_words("fill", base);
`else
    check("fill_count", WIDTH'(got_q.size() - base), 8);
    for (int i = 0; i < 3; i++)
      if (base + i < got_q.size())
        check($sformatf("fill_w%0d", i), got_q[base + i], WIDTH'(2 - i));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound in case a wait loop is never reached.
  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
